rtype_sequencer: RTL and testbench

Multi-cycle control sequencer for the R-type integer datapath. Fetches an instruction over a req/valid handshake and decodes func7/func3/opcode into the ALU control code. It then steps the register file, ALU and write-back through fixed states, advancing the PC. Sits between instruction memory and the register-file/ALU datapath; replaces the free-running combinational decode with a sequenced one.

---
 rtl/riscv_ctrl_pkg.sv | 29 ++
 rtl/rtype_decoder.sv | 35 +++
 rtl/rtype_sequencer.sv | 118 +++++++++++
 tb/tb_rtype_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the R-type control sequencer:
// opcode/func7 values, ALU operation codes and FSM state encoding.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decode: opcode/func3/func7 to ALU code.
// Anything outside the supported R-type set is flagged not legal.
module rtype_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] func7_i,
    output logic [3:0] alu_control_o,
    output logic       legal_o
);

    // Map the func7/func3 pair onto an ALU code when the opcode is R-type
    always_comb begin
        alu_control_o = ALU_ADD;
        legal_o       = 1'b0;
        if (opcode_i == OPC_RTYPE) begin
            legal_o = 1'b1;
            case ({func7_i, func3_i})
                {FUNC7_BASE, 3'b000}: alu_control_o = ALU_ADD;
                {FUNC7_ALT,  3'b000}: alu_control_o = ALU_SUB;
                {FUNC7_BASE, 3'b001}: alu_control_o = ALU_SLL;
                {FUNC7_BASE, 3'b010}: alu_control_o = ALU_SLT;
                {FUNC7_BASE, 3'b011}: alu_control_o = ALU_SLTU;
                {FUNC7_BASE, 3'b100}: alu_control_o = ALU_XOR;
                {FUNC7_BASE, 3'b101}: alu_control_o = ALU_SRL;
                {FUNC7_ALT,  3'b101}: alu_control_o = ALU_SRA;
                {FUNC7_BASE, 3'b110}: alu_control_o = ALU_OR;
                {FUNC7_BASE, 3'b111}: alu_control_o = ALU_AND;
                default:              legal_o       = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the
// R-type datapath; illegal instructions park it in TRAP until reset.
module rtype_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [3:0]      alu_control,
    output logic            reg_write,
    output logic            illegal,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr_count,
    output logic [2:0]      state
);

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [3:0]      alu_q;
    logic            illegal_q;
    logic [XLEN-1:0] pc_q, cnt_q;
    logic [3:0]      dec_alu;
    logic            dec_legal;

    rtype_decoder u_dec (
        .opcode_i      (instr_q[6:0]),
        .func3_i       (instr_q[14:12]),
        .func7_i       (instr_q[31:25]),
        .alu_control_o (dec_alu),
        .legal_o       (dec_legal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; TRAP is left only through reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (run_en) state_d = ST_FETCH;
            ST_FETCH:     if (imem_valid) state_d = ST_DECODE;
            ST_DECODE:    state_d = dec_legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = run_en ? ST_FETCH : ST_IDLE;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Capture the instruction word when memory returns it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_q <= '0;
        else if (state_q == ST_FETCH && imem_valid)
            instr_q <= imem_rdata;
    end

    // Register operand addresses and the ALU code during DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            alu_q <= '0;
        end else if (state_q == ST_DECODE) begin
            rs1_q <= instr_q[19:15];
            rs2_q <= instr_q[24:20];
            rd_q  <= instr_q[11:7];
            if (dec_legal) alu_q <= dec_alu;
        end
    end

    // Sticky illegal flag, set on the way into TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state_q == ST_DECODE && !dec_legal)
            illegal_q <= 1'b1;
    end

    // Retire: advance pc and count on WRITEBACK, both wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else if (state_q == ST_WRITEBACK) begin
            pc_q  <= pc_q + XLEN'(4);
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign reg_write   = (state_q == ST_WRITEBACK) && (rd_q != 5'd0);
    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign rd_addr     = rd_q;
    assign alu_control = alu_q;
    assign illegal     = illegal_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench for rtype_sequencer: directed table,
// hand-written corner sequences and random instructions vs a model.
module tb_rtype_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_control;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] instr_count;
    logic [2:0]  state;

    rtype_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_en      (run_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .pc          (pc),
        .instr_count (instr_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pc_m, cnt_m;
    logic [3:0]  code_m;

    // Legal R-type pairs and their ALU codes
    localparam logic [2:0] F3T [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                                        3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam logic [6:0] F7T [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00,
                                        7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    localparam logic [3:0] CT  [10] = '{4'b0100, 4'b0101, 4'b0001, 4'b1010,
                                        4'b1001, 4'b1000, 4'b0010, 4'b0011,
                                        4'b0111, 4'b0110};

    typedef struct {
        logic [31:0] ins;
        int          dly;
        logic [3:0]  code;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins,
                                       output bit legal,
                                       output logic [3:0] code);
        legal = 1'b0;
        code  = 4'd0;
        if (ins[6:0] == 7'h33)
            for (int i = 0; i < 10; i++)
                if (ins[14:12] == F3T[i] && ins[31:25] == F7T[i]) begin
                    legal = 1'b1;
                    code  = CT[i];
                end
    endfunction

    // Assert reset, check reset values, release with run_en=1
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_wr", 32'(reg_write), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_alu", 32'(alu_control), 32'd0);
        chk("rst_regs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        run_en = 1'b1;
        pc_m   = 32'd0;
        cnt_m  = 32'd0;
        code_m = 4'd0;
        @(negedge clk);
        chk("start_fetch", 32'(state), 32'd1);
    endtask

    // Run one instruction starting from a FETCH negedge
    task automatic do_instr(input logic [31:0] ins, input int dly,
                            input bit keep_run, input bit exp_legal,
                            input logic [3:0] exp_code,
                            input logic [4:0] e1, input logic [4:0] e2,
                            input logic [4:0] ed);
        int c0;
        c0 = cyc;
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, pc_m);
        for (int i = 0; i < dly; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("stall_state", 32'(state), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, pc_m);
            chk("stall_alu", 32'(alu_control), 32'(code_m));
            chk("stall_wr", 32'(reg_write), 32'd0);
            chk("stall_pc", pc, pc_m);
        end
        imem_valid = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        chk("dec_state", 32'(state), 32'd2);
        chk("dec_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        if (!exp_legal) begin
            chk("trap_state", 32'(state), 32'd5);
            chk("trap_ill", 32'(illegal), 32'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("trap_hold", 32'(state), 32'd5);
                chk("trap_req", 32'(imem_req), 32'd0);
                chk("trap_pc", pc, pc_m);
                chk("trap_cnt", instr_count, cnt_m);
                chk("trap_ill_hold", 32'(illegal), 32'd1);
                chk("trap_wr", 32'(reg_write), 32'd0);
            end
            return;
        end
        chk("exe_state", 32'(state), 32'd3);
        chk("exe_alu", 32'(alu_control), 32'(exp_code));
        chk("exe_rs1", 32'(rs1_addr), 32'(e1));
        chk("exe_rs2", 32'(rs2_addr), 32'(e2));
        chk("exe_rd", 32'(rd_addr), 32'(ed));
        chk("exe_wr", 32'(reg_write), 32'd0);
        code_m = exp_code;
        run_en = keep_run;
        @(negedge clk);
        chk("wb_state", 32'(state), 32'd4);
        chk("wb_wr", 32'(reg_write), (ed != 5'd0) ? 32'd1 : 32'd0);
        chk("wb_alu", 32'(alu_control), 32'(code_m));
        chk("wb_pc", pc, pc_m);
        pc_m  = pc_m + 32'd4;
        cnt_m = cnt_m + 32'd1;
        @(negedge clk);
        chk("next_state", 32'(state), keep_run ? 32'd1 : 32'd0);
        chk("ret_pc", pc, pc_m);
        chk("ret_cnt", instr_count, cnt_m);
        chk("ret_wr", 32'(reg_write), 32'd0);
        chk("latency", 32'(cyc - c0), 32'(4 + dly));
    endtask

    initial begin
        bit          lg;
        logic [3:0]  cd;
        logic [31:0] ins;
        int          r, k, dly;
        bit          keep;

        rst_n      = 1'b0;
        run_en     = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;

        tbl[0] = '{32'h002081B3, 0, 4'b0100, 5'd1,  5'd2,  5'd3};
        tbl[1] = '{32'h402081B3, 0, 4'b0101, 5'd1,  5'd2,  5'd3};
        tbl[2] = '{32'h4020D1B3, 0, 4'b0011, 5'd1,  5'd2,  5'd3};
        tbl[3] = '{32'h00208033, 0, 4'b0100, 5'd1,  5'd2,  5'd0};
        tbl[4] = '{32'h002081B3, 3, 4'b0100, 5'd1,  5'd2,  5'd3};
        tbl[5] = '{32'h0020E1B3, 1, 4'b0111, 5'd1,  5'd2,  5'd3};
        tbl[6] = '{32'h007372B3, 0, 4'b0110, 5'd6,  5'd7,  5'd5};
        tbl[7] = '{32'h01DF3FB3, 2, 4'b1001, 5'd30, 5'd29, 5'd31};

        do_reset();

        foreach (tbl[i])
            do_instr(tbl[i].ins, tbl[i].dly, 1'b1, 1'b1, tbl[i].code,
                     tbl[i].rs1, tbl[i].rs2, tbl[i].rd);

        // ADDI: wrong opcode traps
        do_instr(32'h00000013, 0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        do_reset();
        // MUL: func7=0000001 traps
        do_instr(32'h00000013 ^ 32'h00000013 ^ 32'h022081B3, 0, 1'b1,
                 1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        do_reset();

        // Drop run_en during EXECUTE: completes then parks in IDLE
        do_instr(32'h402081B3, 0, 1'b0, 1'b1, 4'b0101, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("park_state", 32'(state), 32'd0);
        chk("park_req", 32'(imem_req), 32'd0);
        run_en = 1'b1;
        @(negedge clk);
        chk("resume_state", 32'(state), 32'd1);

        // Reset pulse during EXECUTE aborts without a write
        imem_valid = 1'b1;
        imem_rdata = 32'h002081B3;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("abort_exe", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_wr", 32'(reg_write), 32'd0);
        @(negedge clk);
        chk("abort_wr2", 32'(reg_write), 32'd0);
        rst_n  = 1'b1;
        pc_m   = 32'd0;
        cnt_m  = 32'd0;
        code_m = 4'd0;
        @(negedge clk);
        chk("abort_fetch", 32'(state), 32'd1);
        chk("abort_cnt", instr_count, 32'd0);

        // Random instructions against the reference decode
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                k   = $urandom_range(0, 9);
                ins = {F7T[k], 5'($urandom), 5'($urandom), F3T[k],
                       5'($urandom), 7'h33};
            end else if (r == 8) begin
                ins = {7'($urandom), 18'($urandom), 7'h33};
            end else begin
                ins = $urandom;
            end
            dly  = $urandom_range(0, 2);
            keep = ($urandom_range(0, 4) != 0);
            ref_decode(ins, lg, cd);
            do_instr(ins, dly, keep, lg, cd,
                     ins[19:15], ins[24:20], ins[11:7]);
            if (!lg) begin
                do_reset();
            end else if (!keep) begin
                run_en = 1'b1;
                @(negedge clk);
                chk("rnd_restart", 32'(state), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
